// File: rtl/pio_pkg.sv
// Shared PIO definitions: action codes, command frame constants and the bridge state type.
package pio_pkg;

  localparam logic [5:0] ACT_NONE         = 6'd0;
  localparam logic [5:0] ACT_IMEM         = 6'd1;
  localparam logic [5:0] ACT_PUSH         = 6'd2;
  localparam logic [5:0] ACT_PULL         = 6'd3;
  localparam logic [5:0] ACT_CONF         = 6'd4;
  localparam logic [5:0] ACT_DIV          = 6'd5;
  localparam logic [5:0] ACT_EN           = 6'd6;
  localparam logic [5:0] ACT_DIS          = 6'd7;
  localparam logic [5:0] ACT_RESTART      = 6'd8;
  localparam logic [5:0] ACT_PINDIR       = 6'd9;
  localparam logic [5:0] ACT_PINS         = 6'd10;
  localparam logic [5:0] ACT_RD_IRQ       = 6'd11;
  localparam logic [5:0] ACT_RD_IRQ_RAW   = 6'd12;
  localparam logic [5:0] ACT_RD_IRQ0_INTE = 6'd13;
  localparam logic [5:0] ACT_RD_IRQ0_INTF = 6'd14;
  localparam logic [5:0] ACT_RD_IRQ0_INTS = 6'd15;
  localparam logic [5:0] ACT_RD_IRQ1_INTE = 6'd16;
  localparam logic [5:0] ACT_RD_IRQ1_INTF = 6'd17;
  localparam logic [5:0] ACT_RD_IRQ1_INTS = 6'd18;
  localparam logic [5:0] ACT_WR_IRQ_CLR   = 6'd19;
  localparam logic [5:0] ACT_WR_IRQ_FORCE = 6'd20;
  localparam logic [5:0] ACT_WR_IRQ0_INTE = 6'd21;
  localparam logic [5:0] ACT_WR_IRQ0_INTF = 6'd22;
  localparam logic [5:0] ACT_WR_IRQ1_INTE = 6'd23;
  localparam logic [5:0] ACT_WR_IRQ1_INTF = 6'd24;

  localparam int FRAME_LEN = 6;

  localparam logic [7:0] ACK_BYTE    = 8'hA5;
  localparam logic [7:0] REJECT_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_ISSUE,
    ST_SETTLE,
    ST_SEND,
    ST_ACK,
    ST_REJECT
  } bridge_state_e;

  function automatic logic is_read_action(input logic [5:0] act);
    return (act == ACT_NONE) || (act == ACT_PULL) ||
           (act >= ACT_RD_IRQ && act <= ACT_RD_IRQ1_INTS);
  endfunction

endpackage

// File: rtl/pio_bridge_ser.sv
// Word-to-byte serializer: loads a 32-bit word and emits it LSB first over valid/ready.
module pio_bridge_ser (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] word,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);

  logic [31:0] shreg;
  logic [2:0]  left;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      left  <= '0;
    end else if (load) begin
      shreg <= word;
      left  <= 3'd4;
    end else if (tx_valid && tx_ready) begin
      shreg <= shreg >> 8;
      left  <= left - 3'd1;
    end
  end

  assign tx_valid = (left != 3'd0);
  assign tx_data  = shreg[7:0];
  assign done     = tx_valid && tx_ready && (left == 3'd1);

endmodule

// File: rtl/pio_host_bridge.sv
// Byte-stream command initiator for the pio register port: 6-byte frames in, action strobes out,
// read data back as 4 bytes. Define PIO_BRIDGE_ACK_EN to add 0xA5/0xEE write/reject responses.
//
// state   | meaning
// COLLECT | accepting frame bytes
// ISSUE   | one-cycle action strobe
// SETTLE  | action NONE, capture dout
// SEND    | return 4 read bytes
// ACK     | return 0xA5 (PIO_BRIDGE_ACK_EN only)
// REJECT  | return 0xEE (PIO_BRIDGE_ACK_EN only)
module pio_host_bridge
  import pio_pkg::*;
#(
  parameter int NUM_MACHINES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [5:0]  action,
  output logic [1:0]  mindex,
  output logic [4:0]  index,
  output logic [31:0] din,
  input  logic [31:0] dout,
  output logic        busy
);

  bridge_state_e state, state_nx;

  logic [2:0]  cnt;
  logic [7:0]  b0_q;
  logic [4:0]  idx_q;
  logic [23:0] dlo_q;
  logic [5:0]  act_q;
  logic        rx_fire, last_byte, frame_ok;
  logic        ser_load, ser_valid, ser_done;
  logic [7:0]  ser_data;

  assign rx_fire   = rx_valid && rx_ready;
  assign last_byte = rx_fire && (cnt == 3'(FRAME_LEN - 1));
  assign frame_ok  = (b0_q[5:0] <= ACT_WR_IRQ1_INTF) && (int'(b0_q[7:6]) < NUM_MACHINES);
  assign busy      = !rx_ready;

  // Frame capture; the strobe fields only move on a valid frame so PIO never sees junk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      b0_q   <= '0;
      idx_q  <= '0;
      dlo_q  <= '0;
      act_q  <= ACT_NONE;
      mindex <= '0;
      index  <= '0;
      din    <= '0;
    end else if (rx_fire) begin
      case (cnt)
        3'd0:    b0_q         <= rx_data;
        3'd1:    idx_q        <= rx_data[4:0];
        3'd2:    dlo_q[7:0]   <= rx_data;
        3'd3:    dlo_q[15:8]  <= rx_data;
        3'd4:    dlo_q[23:16] <= rx_data;
        default: ;
      endcase
      cnt <= last_byte ? 3'd0 : cnt + 3'd1;
      if (last_byte && frame_ok) begin
        act_q  <= b0_q[5:0];
        mindex <= b0_q[7:6];
        index  <= idx_q;
        din    <= {rx_data, dlo_q};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_COLLECT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_COLLECT:
        if (last_byte) begin
`ifdef PIO_BRIDGE_ACK_EN
          state_nx = frame_ok ? ST_ISSUE : ST_REJECT;
`else
          state_nx = frame_ok ? ST_ISSUE : ST_COLLECT;
`endif
        end
      ST_ISSUE:
        if (is_read_action(act_q)) state_nx = ST_SETTLE;
`ifdef PIO_BRIDGE_ACK_EN
        else                       state_nx = ST_ACK;
`else
        else                       state_nx = ST_COLLECT;
`endif
      ST_SETTLE: state_nx = ST_SEND;
      ST_SEND:   if (ser_done) state_nx = ST_COLLECT;
`ifdef PIO_BRIDGE_ACK_EN
      ST_ACK,
      ST_REJECT: if (tx_ready) state_nx = ST_COLLECT;
`endif
      default:   state_nx = ST_COLLECT;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    action   = ACT_NONE;
    ser_load = 1'b0;
    tx_valid = ser_valid;
    tx_data  = ser_data;
    case (state)
      ST_COLLECT: rx_ready = 1'b1;
      ST_ISSUE:   action   = act_q;
      ST_SETTLE:  ser_load = 1'b1;
`ifdef PIO_BRIDGE_ACK_EN
      ST_ACK: begin
        tx_valid = 1'b1;
        tx_data  = ACK_BYTE;
      end
      ST_REJECT: begin
        tx_valid = 1'b1;
        tx_data  = REJECT_BYTE;
      end
`endif
      default: ;
    endcase
  end

  // Load happens at the SETTLE closing edge, after PIO has registered the ISSUE read result.
  pio_bridge_ser u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (ser_load),
    .word     (dout),
    .tx_data  (ser_data),
    .tx_valid (ser_valid),
    .tx_ready (tx_ready),
    .done     (ser_done)
  );

endmodule
